// File: rtl/time_set_controller.sv
// Edit-mode controller for RTC time setting: turns debounced button levels into single-cycle
// step enables for the hour/minute/second counters, with auto-repeat and an idle timeout.
module time_set_controller #(
    parameter int unsigned HOLD_CYCLES    = 50000000,
    parameter int unsigned REPEAT_CYCLES  = 10000000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000000,
    parameter int unsigned CNT_W          = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode_i,
    input  logic       btn_up_i,
    input  logic       btn_down_i,
    output logic       edit_active_o,
    output logic [1:0] field_o,
    output logic       en_hour_o,
    output logic       en_min_o,
    output logic       en_sec_o,
    output logic       up_o,
    output logic       down_o,
    output logic       edit_done_o
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StHour = 2'b01,
        StMin  = 2'b10,
        StSec  = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TmoLast    = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic             mode_hist_q, up_hist_q, dn_hist_q;
    logic             active_q, active_d;
    logic             en_hour_q, en_hour_d, en_min_q, en_min_d, en_sec_q, en_sec_d;
    logic             up_q, up_d, down_q, down_d, done_q, done_d;
    logic             rpt_on_q, rpt_on_d, rpt_up_q, rpt_up_d, rpt_first_q, rpt_first_d;
    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d, tmo_cnt_q, tmo_cnt_d;

    logic             rise_mode, rise_up, rise_dn, rise_step;
    logic             step, step_up;
    logic [CNT_W-1:0] rpt_target;
    state_e           next_field;

    assign rise_mode = btn_mode_i & ~mode_hist_q;
    assign rise_up   = btn_up_i & ~up_hist_q;
    assign rise_dn   = btn_down_i & ~dn_hist_q;
    assign rise_step = rise_up | rise_dn;

    always_comb begin
        next_field = StIdle;
        case (state_q)
            StIdle:  next_field = StHour;
            StHour:  next_field = StMin;
            StMin:   next_field = StSec;
            default: next_field = StIdle;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rpt_on_d    = rpt_on_q;
        rpt_up_d    = rpt_up_q;
        rpt_first_d = rpt_first_q;
        rpt_cnt_d   = rpt_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        done_d      = 1'b0;
        step        = 1'b0;
        step_up     = 1'b0;
        rpt_target  = rpt_first_q ? HoldLast : RepeatLast;

        if (state_q == StIdle) begin
            rpt_on_d  = 1'b0;
            tmo_cnt_d = '0;
            if (rise_mode) begin
                state_d = StHour;
            end
        end else if (rise_mode) begin
            // Mode wins over a coincident up/down rise.
            state_d   = next_field;
            rpt_on_d  = 1'b0;
            tmo_cnt_d = '0;
            done_d    = (state_q == StSec);
        end else if (!rise_step && tmo_cnt_q >= TmoLast) begin
            state_d   = StIdle;
            rpt_on_d  = 1'b0;
            tmo_cnt_d = '0;
            done_d    = 1'b1;
        end else begin
            tmo_cnt_d = rise_step ? '0 : tmo_cnt_q + CNT_W'(1);
            if (btn_up_i && btn_down_i) begin
                rpt_on_d = 1'b0;
            end else if (rise_step) begin
                step        = 1'b1;
                step_up     = rise_up;
                rpt_on_d    = 1'b1;
                rpt_up_d    = rise_up;
                rpt_first_d = 1'b1;
                rpt_cnt_d   = '0;
            end else if (rpt_on_q && (rpt_up_q ? btn_up_i : btn_down_i)) begin
                if (rpt_cnt_q >= rpt_target) begin
                    step        = 1'b1;
                    step_up     = rpt_up_q;
                    rpt_first_d = 1'b0;
                    rpt_cnt_d   = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
                end
            end else begin
                rpt_on_d = 1'b0;
            end
        end

        active_d  = (state_d != StIdle);
        en_hour_d = step && (state_q == StHour);
        en_min_d  = step && (state_q == StMin);
        en_sec_d  = step && (state_q == StSec);
        up_d      = step && step_up;
        down_d    = step && !step_up;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            mode_hist_q <= 1'b0;
            up_hist_q   <= 1'b0;
            dn_hist_q   <= 1'b0;
            active_q    <= 1'b0;
            en_hour_q   <= 1'b0;
            en_min_q    <= 1'b0;
            en_sec_q    <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            done_q      <= 1'b0;
            rpt_on_q    <= 1'b0;
            rpt_up_q    <= 1'b0;
            rpt_first_q <= 1'b0;
            rpt_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_hist_q <= btn_mode_i;
            up_hist_q   <= btn_up_i;
            dn_hist_q   <= btn_down_i;
            active_q    <= active_d;
            en_hour_q   <= en_hour_d;
            en_min_q    <= en_min_d;
            en_sec_q    <= en_sec_d;
            up_q        <= up_d;
            down_q      <= down_d;
            done_q      <= done_d;
            rpt_on_q    <= rpt_on_d;
            rpt_up_q    <= rpt_up_d;
            rpt_first_q <= rpt_first_d;
            rpt_cnt_q   <= rpt_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign field_o       = state_q;
    assign edit_active_o = active_q;
    assign en_hour_o     = en_hour_q;
    assign en_min_o      = en_min_q;
    assign en_sec_o      = en_sec_q;
    assign up_o          = up_q;
    assign down_o        = down_q;
    assign edit_done_o   = done_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: event-time reference model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_time_set_controller;

    localparam int Hold = 8;
    localparam int Rep  = 4;
    localparam int Tmo  = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       edit_active;
    logic [1:0] field;
    logic       en_hour, en_min, en_sec, up, down, edit_done;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: absolute-cycle bookkeeping of last activity and next repeat time.
    int         m_state = 0;
    logic       m_pm = 1'b0, m_pu = 1'b0, m_pd = 1'b0;
    int         m_cyc = 0, m_tmo_start = 0, m_rpt_next = 0;
    bit         m_rpt_on = 1'b0, m_rpt_up = 1'b0;
    logic [8:0] m_exp = '0;

    time_set_controller #(
        .HOLD_CYCLES   (Hold),
        .REPEAT_CYCLES (Rep),
        .TIMEOUT_CYCLES(Tmo),
        .CNT_W         (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_mode_i   (btn_mode),
        .btn_up_i     (btn_up),
        .btn_down_i   (btn_down),
        .edit_active_o(edit_active),
        .field_o      (field),
        .en_hour_o    (en_hour),
        .en_min_o     (en_min),
        .en_sec_o     (en_sec),
        .up_o         (up),
        .down_o       (down),
        .edit_done_o  (edit_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit rm, ru, rd, step, sup, done, held;
        rm = btn_mode && !m_pm;
        ru = btn_up && !m_pu;
        rd = btn_down && !m_pd;
        m_pm = btn_mode;
        m_pu = btn_up;
        m_pd = btn_down;
        step = 1'b0;
        sup = 1'b0;
        done = 1'b0;
        m_cyc++;
        held = m_rpt_up ? btn_up : btn_down;
        if (m_state == 0) begin
            m_rpt_on = 1'b0;
            if (rm) begin
                m_state = 1;
                m_tmo_start = m_cyc;
            end
        end else if (rm) begin
            done = (m_state == 3);
            m_state = (m_state + 1) % 4;
            m_tmo_start = m_cyc;
            m_rpt_on = 1'b0;
        end else if (!(ru || rd) && (m_cyc - m_tmo_start >= Tmo)) begin
            m_state = 0;
            done = 1'b1;
            m_rpt_on = 1'b0;
        end else begin
            if (ru || rd) m_tmo_start = m_cyc;
            if (btn_up && btn_down) begin
                m_rpt_on = 1'b0;
            end else if (ru || rd) begin
                step = 1'b1;
                sup = ru;
                m_rpt_on = 1'b1;
                m_rpt_up = ru;
                m_rpt_next = m_cyc + Hold;
            end else if (m_rpt_on && held) begin
                if (m_cyc == m_rpt_next) begin
                    step = 1'b1;
                    sup = m_rpt_up;
                    m_rpt_next = m_cyc + Rep;
                end
            end else begin
                m_rpt_on = 1'b0;
            end
        end
        m_exp = {m_state != 0, 2'(m_state), step && (m_state == 1), step && (m_state == 2),
                 step && (m_state == 3), step && sup, step && !sup, done};
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_state = 0;
                m_pm = 1'b0;
                m_pu = 1'b0;
                m_pd = 1'b0;
                m_rpt_on = 1'b0;
                m_exp = '0;
            end else begin
                model_edge();
            end
        end
    end

    initial begin
        #2;
        forever begin
            @(negedge clk);
            check("outputs_vs_model",
                  32'({edit_active, field, en_hour, en_min, en_sec, up, down, edit_done}),
                  32'(m_exp));
        end
    end

    task automatic cyc_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int first;
        #1 rst = 1'b1;
        cyc_n(3);
        check("reset_outputs",
              32'({edit_active, field, en_hour, en_min, en_sec, up, down, edit_done}), 32'd0);
        rst = 1'b0;
        cyc_n(2);

        // Field walk and exit by mode.
        for (int i = 1; i <= 3; i++) begin
            btn_mode = 1'b1;
            @(negedge clk);
            btn_mode = 1'b0;
            check("field_walk", 32'(field), 32'(i));
            check("active_walk", 32'(edit_active), 32'd1);
            cyc_n(1);
        end
        btn_mode = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
        check("exit_state", 32'({edit_active, field}), 32'd0);
        check("exit_done", 32'(edit_done), 32'd1);
        cyc_n(1);
        check("done_one_cycle", 32'(edit_done), 32'd0);

        // Short up tap in HOUR.
        btn_mode = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
        cyc_n(1);
        btn_up = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (j == 2) btn_up = 1'b0;
            check("tap_en_hour", 32'({en_hour, up, down}), (j == 0) ? 32'b110 : 32'b000);
            check("tap_other", 32'({en_min, en_sec}), 32'd0);
        end

        // Held down in MIN: steps at k, k+8, k+12, k+16.
        btn_mode = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
        cyc_n(1);
        btn_down = 1'b1;
        for (int j = 0; j < 24; j++) begin
            @(negedge clk);
            if (j == 19) btn_down = 1'b0;
            check("repeat_en_min", 32'({en_min, up, down}),
                  (j == 0 || j == 8 || j == 12 || j == 16) ? 32'b101 : 32'b000);
        end

        // Both buttons in SEC, then down released with up still held.
        btn_mode = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
        cyc_n(1);
        btn_up = 1'b1;
        btn_down = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("both_no_step", 32'({en_hour, en_min, en_sec}), 32'd0);
        end
        btn_down = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check("held_no_step", 32'({en_hour, en_min, en_sec}), 32'd0);
        end
        btn_up = 1'b0;
        cyc_n(1);
        btn_up = 1'b1;
        @(negedge clk);
        btn_up = 1'b0;
        check("fresh_rise_step", 32'({en_sec, up, down}), 32'b110);
        cyc_n(1);
        btn_mode = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
        check("sec_exit_done", 32'({edit_done, field}), 32'b100);
        cyc_n(1);

        // Inactivity timeout from HOUR.
        btn_mode = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
        first = -1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (edit_done && first < 0) first = j;
        end
        check("timeout_exit_cycle", 32'(first), 32'd32);
        check("timeout_idle", 32'({edit_active, field}), 32'd0);

        // Tap at cycle 20 restarts the timeout.
        btn_mode = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
        first = -1;
        for (int j = 1; j <= 60; j++) begin
            @(negedge clk);
            if (edit_done && first < 0) first = j;
            if (j == 20) check("timeout_tap_step", 32'(en_hour), 32'd1);
            if (j == 19) btn_up = 1'b1;
            if (j == 20) btn_up = 1'b0;
        end
        check("timeout_restart_cycle", 32'(first), 32'd52);

        // Asynchronous reset mid-edit with up held.
        btn_mode = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
        cyc_n(1);
        btn_mode = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
        check("pre_reset_field", 32'(field), 32'd2);
        cyc_n(1);
        btn_up = 1'b1;
        cyc_n(3);
        #2 rst = 1'b1;
        #1;
        check("async_reset",
              32'({edit_active, field, en_hour, en_min, en_sec, up, down, edit_done}), 32'd0);
        cyc_n(2);
        rst = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check("idle_ignores_up",
                  32'({edit_active, field, en_hour, en_min, en_sec, edit_done}), 32'd0);
        end
        btn_up = 1'b0;
        cyc_n(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
- Edit-mode controller for the RTC time-setting path.
- Converts debounced push-button levels into single-cycle step commands for three wrap-around field counters: hours (0-23), minutes (0-59) and seconds (0-59).
- Sequences the field cursor and applies auto-repeat on held buttons.
- Leaves edit mode on user command or inactivity timeout, and signals edit completion so the time can be written back to the RTC.

Parameters:
- HOLD_CYCLES, 50000000: cycles a direction button must stay held after the initial step before the first repeat step.
- REPEAT_CYCLES, 10000000: cycles between subsequent repeat steps while held.
- TIMEOUT_CYCLES, 1000000000: idle cycles in edit mode before automatic exit.
- CNT_W, 30: width of the internal hold, repeat and timeout counters. Must hold the largest cycle parameter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- btn_mode  in  1  debounced level; a rising edge advances the edit field.
- btn_up  in  1  debounced level; increment request.
- btn_down  in  1  debounced level; decrement request.
- edit_active  out  1  high while any field is being edited.
- field  out  2  00 none, 01 hours, 10 minutes, 11 seconds.
- en_hour  out  1  one-cycle step enable to the hour counter.
- en_min  out  1  one-cycle step enable to the minute counter.
- en_sec  out  1  one-cycle step enable to the second counter.
- up  out  1  direction qualifier; high only together with an en_* pulse.
- down  out  1  direction qualifier; high only together with an en_* pulse.
- edit_done  out  1  one-cycle pulse on every exit from edit mode.

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0; button-history registers 0. Reset asserted mid-edit aborts immediately and does not produce edit_done.
- All outputs are registered.
- Rising edge detect: a rise is seen at edge k when the button is sampled 1 and its history register holds 0. History registers update every edge.
- Any output caused by a rise at edge k is high for exactly the cycle between edge k and edge k+1.
- FSM states: IDLE, HOUR, MIN, SEC.
  - A btn_mode rise steps IDLE->HOUR->MIN->SEC->IDLE.
  - SEC->IDLE on btn_mode rise pulses edit_done.
  - field and edit_active follow the state.
- IDLE: btn_up and btn_down are ignored; no en_* pulses.
- Edit states, step generation:
  - A btn_up rise with btn_down sampled 0 gives one en_<field> pulse, with up=1 and down=0.
  - Decrement is symmetric.
  - Exactly one en_* is high at a time, and only for the current field.
- Simultaneous events:
  - btn_mode rise in the same cycle as an up/down rise: the mode action wins and no step is issued.
  - btn_up and btn_down both high: no step; the repeat logic is cleared.
- Auto-repeat:
  - After an initial step at edge k, with the same single direction held continuously, a repeat step occurs at edge k+HOLD_CYCLES.
  - Further repeat steps occur every REPEAT_CYCLES thereafter.
  - Release, the opposite button pressing, or a field change clears the repeat logic. The next step then needs a fresh rise.
- Timeout:
  - The counter is cleared on entry to edit mode and on any button rise.
  - It increments every cycle in HOUR, MIN or SEC.
  - When it reaches TIMEOUT_CYCLES-1, the next edge goes to IDLE with an edit_done pulse. A held button does not refresh the timeout; only rises do.
- Wrap-around of the field values is performed by the counters; this block never inspects counter values.
- Counter arithmetic is unsigned, CNT_W bits, saturating at the terminal compare and never wrapping.

Test Plan (HOLD_CYCLES=8, REPEAT_CYCLES=4, TIMEOUT_CYCLES=32):
- Reset then three btn_mode presses:
  - field goes 01, 10, 11, one cycle after each rise.
  - A fourth press gives field=00, edit_active=0 and one edit_done pulse.
- In HOUR, tap btn_up for 3 cycles: exactly one en_hour pulse with up=1, down=0. en_min and en_sec stay 0.
- In MIN, hold btn_down for 20 cycles after the rise at edge k:
  - en_min pulses at edges k, k+8, k+12 and k+16; down=1 on each.
  - No pulses after release.
- btn_up and btn_down rise together in SEC: no en_* pulse. Then btn_down falls with btn_up still held: no step until a new btn_up rise.
- In HOUR, no button activity:
  - Exit to IDLE with edit_done 32 cycles after entry.
  - A btn_up tap at cycle 20 restarts the count, so exit comes 32 cycles after the tap.
- Assert rst during MIN with btn_up held:
  - All outputs drop to 0 asynchronously; no edit_done.
  - After release, btn_up still held gives no step, since IDLE ignores it.
